// File: rtl/multicycle_core.sv
// multicycle_core: parametrised multicycle accumulator-style core (regfile, ALU, CZN flags, PC, FSM)
// with a req/ack memory port that tolerates wait states.
module multicycle_core #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    REG_COUNT  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            czn,
  output logic                  halted,
  output logic                  retire
);
  localparam int RS  = $clog2(REG_COUNT);
  localparam int EXT = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CW  = $clog2(EXT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXTW, EXEC, MEM, HALT} state_t;
  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   ir;
  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
  logic [2:0]              czn_q;
  logic [EXT*DATA_WIDTH-1:0] ext_buf;
  logic [CW-1:0]           cnt;
  logic [3:0]              op;
  logic [RS-1:0]           rd, rs;
  logic [DATA_WIDTH-1:0]   rd_v, rs_v;
  logic [DATA_WIDTH:0]     alu;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    done, last_w, taken, unused_bits;
  assign op          = ir[DATA_WIDTH-1 -: 4];
  assign rd          = ir[2*RS-1:RS];
  assign rs          = ir[RS-1:0];
  assign rd_v        = regs[rd];
  assign rs_v        = regs[rs];
  assign addr        = ext_buf[ADDR_WIDTH-1:0];
  assign unused_bits = ^{ir, ext_buf};
  // Bit DATA_WIDTH of alu is the carry/borrow/shifted-out bit feeding C.
  assign alu = op == 4'h0 ? {1'b0, rd_v} + {1'b0, rs_v} :
               op == 4'h1 ? {1'b0, rd_v} + {1'b0, rs_v} + {{DATA_WIDTH{1'b0}}, czn_q[0]} :
               op == 4'h2 ? {1'b0, rd_v} - {1'b0, rs_v} :
               op == 4'h3 ? {1'b0, rd_v & rs_v} :
               op == 4'h4 ? {1'b0, rd_v | rs_v} :
               op == 4'h5 ? {1'b0, rd_v ^ rs_v} :
               op == 4'h7 ? {rs_v, 1'b0} : {1'b0, rs_v};
  assign taken  = op == 4'hB || (op == 4'hC && czn_q[1]) || (op == 4'hD && czn_q[0]) ||
                  (op == 4'hE && czn_q[2]);
  assign last_w = op == 4'h8 ? cnt == '0 : cnt == CW'(EXT - 1);
  assign mem_req   = rst && (state == FETCH || state == EXTW || state == MEM);
  assign done      = mem_req && mem_ack;
  assign mem_we    = state == MEM && op == 4'hA;
  assign mem_addr  = state == MEM ? addr : pc_q;
  assign mem_wdata = rd_v;
  assign retire    = rst && (state == EXEC || (state == MEM && mem_ack));
  assign halted    = state == HALT;
  assign pc        = pc_q;
  assign czn       = czn_q;
  always_comb begin
    state_d = state;
    case (state)
      FETCH:   state_d = done ? DECODE : FETCH;
      DECODE:  state_d = op == 4'hF ? HALT : op[3] ? EXTW : EXEC;
      EXTW:    state_d = !(done && last_w) ? EXTW : (op == 4'h9 || op == 4'hA) ? MEM : EXEC;
      EXEC:    state_d = FETCH;
      MEM:     state_d = done ? FETCH : MEM;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      czn_q   <= '0;
      ir      <= '0;
      ext_buf <= '0;
      cnt     <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      state <= state_d;
      if ((state == FETCH || state == EXTW) && done) pc_q <= pc_q + ADDR_WIDTH'(1);
      if (state == FETCH && done) ir <= mem_rdata;
      if (state == DECODE) cnt <= '0;
      if (state == EXTW && done) begin
        ext_buf[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        cnt <= cnt + CW'(1);
      end
      if (state == EXEC && op <= 4'h8) regs[rd] <= op == 4'h8 ? ext_buf[DATA_WIDTH-1:0] : alu[DATA_WIDTH-1:0];
      if (state == EXEC && (op <= 4'h5 || op == 4'h7))
        czn_q <= {alu[DATA_WIDTH-1], alu[DATA_WIDTH-1:0] == '0, alu[DATA_WIDTH]};
      if (state == EXEC && taken) pc_q <= addr;
      if (state == MEM && done && op == 4'h9) regs[rd] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and randomized checks of multicycle_core against an ISA-level model.
module tb_multicycle_core;
  localparam int AW = 13;
  localparam int DW = 8;
  logic clk = 0, rst = 0;
  logic mem_req, mem_we, mem_ack, halted, retire;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0] czn;
  logic mem_req2, mem_we2, mem_ack2, halted2, retire2;
  logic [AW-1:0] mem_addr2, pc2;
  logic [DW-1:0] mem_wdata2, mem_rdata2;
  logic [2:0] czn2;
  logic [7:0] mem [8192];
  logic [7:0] mm [8192];
  int wait_n = 0, wcnt = 0, lp = 0, cyc = 0;
  int vectors = 0, miscompares = 0;
  int retq[$], expq[$];
  int unstable = 0, wr_cnt = 0, wr_addr0 = 0, wr_data0 = 0;
  logic p_wait = 0, p_we = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wd = '0;
  int m_r[4];
  logic [2:0] m_czn;
  int m_pc;

  always #5 clk = ~clk;
  assign mem_ack    = mem_req && (wcnt >= wait_n);
  assign mem_rdata  = mem[mem_addr];
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = (mem_addr2 == 13'h1FFF) ? 8'h06 : (mem_addr2 == 13'h0000) ? 8'hF0 : 8'h00;

  multicycle_core u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .czn(czn),
    .halted(halted), .retire(retire)
  );
  multicycle_core #(.RESET_PC(13'h1FFF)) u_dut2 (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .pc(pc2), .czn(czn2),
    .halted(halted2), .retire(retire2)
  );

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) begin mem[i] = '0; mm[i] = '0; end
    lp = 0;
  endtask

  task automatic put(input int b);
    mem[lp] = 8'(b);
    mm[lp]  = 8'(b);
    lp = (lp + 1) % 8192;
  endtask

  // One clock of the memory model; entered and left just after a falling edge.
  task automatic step();
    int nxt;
    cyc++;
    if (retire) retq.push_back(cyc);
    if (p_wait && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) unstable++;
    p_wait = mem_req && !mem_ack;
    p_addr = mem_addr;
    p_we   = mem_we;
    p_wd   = mem_wdata;
    if (mem_req && mem_ack && mem_we) begin
      if (wr_cnt == 0) begin wr_addr0 = int'(mem_addr); wr_data0 = int'(mem_wdata); end
      wr_cnt++;
      mem[mem_addr] = mem_wdata;
    end
    nxt = (mem_req && !mem_ack) ? wcnt + 1 : 0;
    @(negedge clk);
    wcnt = nxt;
    #1;
  endtask

  task automatic apply_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic release_rst();
    cyc = 0; retq.delete(); unstable = 0; wr_cnt = 0; p_wait = 0; wcnt = 0;
    rst = 1;
    #1;
  endtask

  task automatic run(input int max_c, output bit ok);
    ok = 0;
    for (int i = 0; i < max_c; i++) begin
      if (halted) begin ok = 1; break; end
      step();
    end
  endtask

  // Instruction-level interpreter: retire cycle = sum of per-phase costs with w wait states.
  task automatic model_run(input int start, input int w);
    int p, c, ins, op, rd, rs, a, x, y, res;
    bit cf;
    p = start; c = 0; expq.delete(); m_czn = '0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      ins = int'(mm[p]); p = (p + 1) % 8192; c += w + 2;
      op = ins >> 4; rd = (ins >> 2) & 3; rs = ins & 3;
      if (op == 15) break;
      a = 0;
      if (op >= 8)
        for (int i = 0; i < ((op == 8) ? 1 : 2); i++) begin
          a = a | (int'(mm[p]) << (8 * i)); p = (p + 1) % 8192; c += w + 1;
        end
      a = a % 8192;
      x = m_r[rd]; y = m_r[rs];
      if (op <= 7 && op != 6) begin
        case (op)
          0: res = x + y;
          1: res = x + y + int'(m_czn[0]);
          2: res = x - y;
          3: res = x & y;
          4: res = x | y;
          5: res = x ^ y;
          default: res = y * 2;
        endcase
        cf = (op <= 1 || op == 7) ? (res > 255) : (op == 2) ? (y > x) : 1'b0;
        res = res & 255;
        m_r[rd] = res;
        m_czn = {res >= 128, res == 0, cf};
      end
      if (op == 6) m_r[rd] = y;
      if (op == 8) m_r[rd] = a;
      if (op == 9) m_r[rd] = int'(mm[a]);
      if (op == 10) mm[a] = 8'(m_r[rd]);
      if (op == 11 || (op == 12 && m_czn[1]) || (op == 13 && m_czn[0]) || (op == 14 && m_czn[2])) p = a;
      c += (op == 9 || op == 10) ? w + 1 : 1;
      expq.push_back(c);
    end
    m_pc = p;
  endtask

  task automatic load_ldi_add();
    clear_mem();
    put(8'h84); put(8'h05); put(8'h88); put(8'h03); put(8'h06);
    put(8'hA4); put(8'h00); put(8'h01); put(8'hA8); put(8'h01); put(8'h01); put(8'hF0);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req); end
    vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire: got %b want 0", retire); end
    vectors++; if (pc !== 13'h0000) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
    vectors++; if (czn !== 3'b000) begin miscompares++; $display("FAIL reset_czn: got %b want 000", czn); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++; if (pc2 !== 13'h1FFF) begin miscompares++; $display("FAIL reset_pc2: got %h want 1fff", pc2); end
  endtask

  task automatic test_ldi_add();
    bit ok;
    load_ldi_add();
    wait_n = 0;
    apply_reset(); release_rst(); run(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ldi_add_halt: got halted=%b want 1", halted); end
    vectors++;
    if (retq.size() < 3 || retq[0] != 4 || retq[1] != 8 || retq[2] != 11) begin
      miscompares++; $display("FAIL ldi_add_retire: got %p want 4,8,11 first", retq);
    end
    vectors++; if (mem[13'h100] !== 8'h08) begin miscompares++; $display("FAIL ldi_add_r1: got %h want 08", mem[13'h100]); end
    vectors++; if (mem[13'h101] !== 8'h03) begin miscompares++; $display("FAIL ldi_add_r2: got %h want 03", mem[13'h101]); end
    vectors++; if (czn !== 3'b000) begin miscompares++; $display("FAIL ldi_add_czn: got %b want 000", czn); end
  endtask

  task automatic test_sub_jc();
    bit ok;
    clear_mem();
    put(8'h84); put(8'h03); put(8'h88); put(8'h05); put(8'h26); put(8'hD0); put(8'h34); put(8'h12);
    lp = 13'h1234;
    put(8'hA4); put(8'h00); put(8'h01); put(8'hF0);
    wait_n = 0;
    apply_reset(); release_rst(); run(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL sub_jc_halt: got halted=%b want 1", halted); end
    vectors++; if (czn !== 3'b101) begin miscompares++; $display("FAIL sub_jc_czn: got %b want 101", czn); end
    vectors++; if (mem[13'h100] !== 8'hFE) begin miscompares++; $display("FAIL sub_jc_r1: got %h want fe", mem[13'h100]); end
    vectors++; if (pc !== 13'h1238) begin miscompares++; $display("FAIL sub_jc_pc: got %h want 1238", pc); end
  endtask

  task automatic test_st_ld();
    bit ok;
    clear_mem();
    put(8'h00); put(8'h84); put(8'hAB); put(8'hA4); put(8'h00); put(8'h01);
    put(8'h9C); put(8'h00); put(8'h01); put(8'hAC); put(8'h01); put(8'h01); put(8'hF0);
    wait_n = 0;
    apply_reset(); release_rst(); run(300, ok);
    vectors++; if (!ok || wr_cnt != 2) begin miscompares++; $display("FAIL st_ld_writes: got %0d halted=%b want 2", wr_cnt, halted); end
    vectors++; if (wr_addr0 != 'h100) begin miscompares++; $display("FAIL st_addr: got %h want 0100", wr_addr0); end
    vectors++; if (wr_data0 != 'hAB) begin miscompares++; $display("FAIL st_wdata: got %h want ab", wr_data0); end
    vectors++; if (mem[13'h101] !== 8'hAB) begin miscompares++; $display("FAIL ld_r3: got %h want ab", mem[13'h101]); end
    vectors++; if (czn !== 3'b010) begin miscompares++; $display("FAIL st_ld_czn: got %b want 010", czn); end
  endtask

  task automatic test_wait_states();
    bit ok, qbad;
    load_ldi_add();
    model_run(0, 3);
    wait_n = 3;
    apply_reset(); release_rst(); run(600, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wait_halt: got halted=%b want 1", halted); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL wait_stable: got %0d changes want 0", unstable); end
    vectors++;
    if (retq.size() < 3 || retq[2] - retq[1] != 6) begin
      miscompares++; $display("FAIL wait_add_latency: got %p want add retire 6 after ldi", retq);
    end
    qbad = retq.size() != expq.size();
    foreach (expq[i]) if (!qbad && retq[i] != expq[i]) qbad = 1;
    vectors++; if (qbad) begin miscompares++; $display("FAIL wait_retire: got %p want %p", retq, expq); end
    vectors++;
    if (mem[13'h100] !== 8'h08 || mem[13'h101] !== 8'h03) begin
      miscompares++; $display("FAIL wait_result: got %h %h want 08 03", mem[13'h100], mem[13'h101]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mem();
    put(8'h00); put(8'hB0); put(8'h00); put(8'h05);
    lp = 13'h500; put(8'hF0);
    wait_n = 0;
    apply_reset(); release_rst();
    step(); step(); step();
    wait_n = 50;
    step(); step();
    vectors++; if (mem_req !== 1'b1 || czn !== 3'b010) begin miscompares++; $display("FAIL mid_pre: got req=%b czn=%b want 1 010", mem_req, czn); end
    rst = 0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
    @(negedge clk); #1;
    vectors++; if (pc !== 13'h0000) begin miscompares++; $display("FAIL mid_pc: got %h want 0000", pc); end
    vectors++; if (czn !== 3'b000) begin miscompares++; $display("FAIL mid_czn: got %b want 000", czn); end
    vectors++; if (mem_req !== 1'b0 || retire !== 1'b0) begin miscompares++; $display("FAIL mid_idle: got req=%b ret=%b want 0 0", mem_req, retire); end
    wait_n = 0;
    release_rst();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 13'h0000) begin miscompares++; $display("FAIL mid_refetch: got req=%b addr=%h want 1 0000", mem_req, mem_addr); end
    run(100, ok);
    vectors++; if (!ok || pc !== 13'h0501 || czn !== 3'b010) begin miscompares++; $display("FAIL mid_rerun: got pc=%h czn=%b want 0501 010", pc, czn); end
  endtask

  task automatic test_wrap_halt();
    int r2q[$];
    int bad1, bad2;
    logic [AW-1:0] a4;
    logic r4;
    clear_mem();
    put(8'hF0);
    wait_n = 0; bad1 = 0; bad2 = 0; a4 = '0; r4 = 0;
    apply_reset(); release_rst();
    vectors++; if (mem_addr2 !== 13'h1FFF || pc2 !== 13'h1FFF) begin miscompares++; $display("FAIL wrap_start: got addr=%h pc=%h want 1fff", mem_addr2, pc2); end
    for (int k = 1; k <= 30; k++) begin
      if (retire2) r2q.push_back(k);
      if (k == 4) begin a4 = mem_addr2; r4 = mem_req2; end
      if (k >= 6 && (!halted2 || mem_req2 || retire2)) bad2++;
      if (k >= 3 && (!halted || mem_req || retire)) bad1++;
      step();
    end
    vectors++; if (r2q.size() != 1 || r2q[0] != 3) begin miscompares++; $display("FAIL wrap_retire: got %p want 3", r2q); end
    vectors++; if (a4 !== 13'h0000 || r4 !== 1'b1) begin miscompares++; $display("FAIL wrap_addr: got %h req=%b want 0000 1", a4, r4); end
    vectors++; if (bad2 != 0) begin miscompares++; $display("FAIL halt2_idle: got %0d bad cycles want 0", bad2); end
    vectors++; if (bad1 != 0 || retq.size() != 0) begin miscompares++; $display("FAIL halt_idle: got %0d bad cycles %0d retires want 0 0", bad1, retq.size()); end
    vectors++; if (pc2 !== 13'h0001) begin miscompares++; $display("FAIL halt2_pc: got %h want 0001", pc2); end
  endtask

  task automatic test_random();
    bit ok, qbad;
    int k, rd, t, badm;
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      for (int i = 0; i < 4; i++) begin put(8'h80 | (i << 2)); put(int'($urandom_range(0, 255))); end
      for (int n = 0; n < 12; n++) begin
        k = int'($urandom_range(0, 9));
        rd = int'($urandom_range(0, 3));
        if (k <= 5) put((int'($urandom_range(0, 7)) << 4) | (rd << 2) | int'($urandom_range(0, 3)));
        else if (k <= 7) begin
          t = lp + 5;
          put(int'($urandom_range(11, 14)) << 4); put(t & 255); put(t >> 8);
          put(8'h80 | (rd << 2)); put(int'($urandom_range(0, 255)));
        end else begin
          put(((k == 8) ? 8'hA0 : 8'h90) | (rd << 2)); put(int'($urandom_range(8'h80, 8'h87))); put(1);
        end
      end
      for (int i = 0; i < 4; i++) begin put(8'hA0 | (i << 2)); put(i); put(1); end
      put(8'hF0);
      wait_n = int'($urandom_range(0, 2));
      model_run(0, wait_n);
      apply_reset(); release_rst(); run(3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rnd%0d_halt: got halted=%b want 1", it, halted); end
      vectors++; if (czn !== m_czn) begin miscompares++; $display("FAIL rnd%0d_czn: got %b want %b", it, czn, m_czn); end
      vectors++; if (pc !== AW'(m_pc)) begin miscompares++; $display("FAIL rnd%0d_pc: got %h want %h", it, pc, m_pc); end
      qbad = retq.size() != expq.size();
      foreach (expq[i]) if (!qbad && retq[i] != expq[i]) qbad = 1;
      vectors++; if (qbad) begin miscompares++; $display("FAIL rnd%0d_retire: got %0d retires want %0d (timing differs)", it, retq.size(), expq.size()); end
      badm = -1;
      for (int i = 0; i < 8192; i++) if (badm < 0 && mem[i] !== mm[i]) badm = i;
      vectors++; if (badm >= 0) begin miscompares++; $display("FAIL rnd%0d_mem: addr %h got %h want %h", it, badm, mem[badm], mm[badm]); end
      vectors++; if (unstable != 0) begin miscompares++; $display("FAIL rnd%0d_stable: got %0d changes want 0", it, unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_sub_jc();
    test_st_ld();
    test_wait_states();
    test_reset_mid();
    test_wrap_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
